// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and geometry helpers for the
// direct-mapped write-back data cache and its DDR line initiator.
package dcache_pkg;

  localparam int ADDR_W   = 27;
  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    RF_REQ,
    RF_WAIT
  } state_t;

  function automatic int index_w_of(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w_of(input int addr_w, input int index_w);
    return addr_w - OFFSET_W - index_w;
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Tag/valid/dirty/data arrays behind one shared index; reads are combinational,
// writes land on the clock edge. Also merges a single word into a line.
module dcache_store #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 17,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               fill_sel,
  input  logic [LINE_W-1:0]  fill_line,
  input  logic               merge_en,
  input  logic [1:0]         word_off,
  input  logic [31:0]        word,
  output logic [LINE_W-1:0]  merged_line,
  input  logic               line_we,
  input  logic               meta_we,
  input  logic               meta_valid,
  input  logic               meta_dirty,
  input  logic [TAG_W-1:0]   meta_tag
);
  import dcache_pkg::*;

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Base is either the resident line (store hit) or the DDR refill line.
  always_comb begin
    merged_line = fill_sel ? fill_line : rd_line;
    if (merge_en) begin
      merged_line[word_off*WORD_W +: WORD_W] = word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= meta_valid;
      dirty_q[idx] <= meta_dirty;
    end
  end

  // Tags and data carry no reset; a cleared valid bit makes them unreachable.
  always_ff @(posedge clk) begin
    if (meta_we) begin
      tag_q[idx] <= meta_tag;
    end
    if (line_we) begin
      data_q[idx] <= merged_line;
    end
  end

endmodule

// File: rtl/dcache_ddr_initiator.sv
// Direct-mapped write-back/write-allocate cache controller: hit done two edges after
// request; miss waits on DDR rd_fin (and wr_fin first for a dirty victim), one request at a time.
module dcache_ddr_initiator #(
  parameter int ADDR_W  = dcache_pkg::ADDR_W,
  parameter int INDEX_W = 6,
  parameter int LINE_W  = dcache_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] cache2DDR_rd_addr,
  output logic              cache2DDR_rd_en,
  input  logic              DDR2cache_rd_fin,
  input  logic [LINE_W-1:0] DDR2cache_rd_data,
  output logic [ADDR_W-1:0] cache2DDR_wr_addr,
  output logic [LINE_W-1:0] cache2DDR_wr_data,
  output logic              cache2DDR_wr_en,
  input  logic              DDR2cache_wr_fin
);
  import dcache_pkg::*;

  localparam int TAG_W = tag_w_of(ADDR_W, INDEX_W);

  state_t state_q, state_d;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_off;
  logic               req_we;
  logic [31:0]        req_wdata;

  logic               st_valid, st_dirty;
  logic [TAG_W-1:0]   st_tag;
  logic [LINE_W-1:0]  st_line, merged_line;
  logic               hit;

  logic               fill_sel, line_we, meta_we, meta_valid, meta_dirty;
  logic [TAG_W-1:0]   meta_tag;

  logic               done_d, busy_d, rd_en_d, wr_en_d;
  logic [31:0]        rdata_d;
  logic [ADDR_W-1:0]  rd_addr_d, wr_addr_d;
  logic [LINE_W-1:0]  wr_data_d;

  // Byte-lane bits of the address have no meaning for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  dcache_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_store (
    .clk         (clk),
    .rstn        (rstn),
    .idx         (req_idx),
    .rd_valid    (st_valid),
    .rd_dirty    (st_dirty),
    .rd_tag      (st_tag),
    .rd_line     (st_line),
    .fill_sel    (fill_sel),
    .fill_line   (DDR2cache_rd_data),
    .merge_en    (req_we),
    .word_off    (req_off),
    .word        (req_wdata),
    .merged_line (merged_line),
    .line_we     (line_we),
    .meta_we     (meta_we),
    .meta_valid  (meta_valid),
    .meta_dirty  (meta_dirty),
    .meta_tag    (meta_tag)
  );

  assign hit = st_valid && (st_tag == req_tag);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = LOOKUP;
      LOOKUP: begin
        if (hit)                        state_d = IDLE;
        else if (st_valid && st_dirty)  state_d = WB_REQ;
        else                            state_d = RF_REQ;
      end
      WB_REQ:  state_d = WB_WAIT;
      WB_WAIT: if (DDR2cache_wr_fin) state_d = RF_REQ;
      RF_REQ:  state_d = RF_WAIT;
      RF_WAIT: if (DDR2cache_rd_fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs plus the store write controls.
  always_comb begin
    done_d     = 1'b0;
    busy_d     = (state_d != IDLE);
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    rdata_d    = cpu_rdata;
    rd_addr_d  = cache2DDR_rd_addr;
    wr_addr_d  = cache2DDR_wr_addr;
    wr_data_d  = cache2DDR_wr_data;
    fill_sel   = 1'b0;
    line_we    = 1'b0;
    meta_we    = 1'b0;
    meta_valid = st_valid;
    meta_dirty = st_dirty;
    meta_tag   = st_tag;
    case (state_q)
      LOOKUP: begin
        if (hit) begin
          done_d  = 1'b1;
          rdata_d = st_line[req_off*WORD_W +: WORD_W];
          if (req_we) begin
            line_we    = 1'b1;
            meta_we    = 1'b1;
            meta_dirty = 1'b1;
          end
        end
      end
      WB_REQ: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {st_tag, req_idx, {OFFSET_W{1'b0}}};
        wr_data_d = st_line;
      end
      WB_WAIT: begin
        if (DDR2cache_wr_fin) begin
          meta_we    = 1'b1;
          meta_dirty = 1'b0;
        end
      end
      RF_REQ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
      end
      RF_WAIT: begin
        if (DDR2cache_rd_fin) begin
          fill_sel   = 1'b1;
          line_we    = 1'b1;
          meta_we    = 1'b1;
          meta_valid = 1'b1;
          meta_dirty = req_we;
          meta_tag   = req_tag;
          done_d     = 1'b1;
          rdata_d    = merged_line[req_off*WORD_W +: WORD_W];
        end
      end
      default: ;
    endcase
    if (!rstn) begin
      line_we = 1'b0;
      meta_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cpu_done          <= 1'b0;
      cpu_busy          <= 1'b0;
      cpu_rdata         <= '0;
      cache2DDR_rd_en   <= 1'b0;
      cache2DDR_wr_en   <= 1'b0;
      cache2DDR_rd_addr <= '0;
      cache2DDR_wr_addr <= '0;
      cache2DDR_wr_data <= '0;
    end else begin
      cpu_done          <= done_d;
      cpu_busy          <= busy_d;
      cpu_rdata         <= rdata_d;
      cache2DDR_rd_en   <= rd_en_d;
      cache2DDR_wr_en   <= wr_en_d;
      cache2DDR_rd_addr <= rd_addr_d;
      cache2DDR_wr_addr <= wr_addr_d;
      cache2DDR_wr_data <= wr_data_d;
    end
  end

  // The request is captured once and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cpu_req) begin
      req_tag   <= cpu_addr[ADDR_W-1:OFFSET_W+INDEX_W];
      req_idx   <= cpu_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
      req_off   <= cpu_addr[3:2];
      req_we    <= cpu_we;
      req_wdata <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ddr_initiator.sv
// Bench for dcache_ddr_initiator: DDR responder with programmable fin delay and an
// architectural-memory reference model for randomized load/store traffic.
module tb_dcache_ddr_initiator;

  logic         clk = 1'b0;
  logic         rstn;
  logic         cpu_req, cpu_we;
  logic [26:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_done, cpu_busy;
  logic [26:0]  rd_addr, wr_addr;
  logic         rd_en, wr_en, rd_fin, wr_fin;
  logic [127:0] rd_data, wr_data;

  always #5 clk = ~clk;

  dcache_ddr_initiator dut (
    .clk               (clk),
    .rstn              (rstn),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_done          (cpu_done),
    .cpu_busy          (cpu_busy),
    .cache2DDR_rd_addr (rd_addr),
    .cache2DDR_rd_en   (rd_en),
    .DDR2cache_rd_fin  (rd_fin),
    .DDR2cache_rd_data (rd_data),
    .cache2DDR_wr_addr (wr_addr),
    .cache2DDR_wr_data (wr_data),
    .cache2DDR_wr_en   (wr_en),
    .DDR2cache_wr_fin  (wr_fin)
  );

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, wr_cnt = 0, both_err = 0, stab_err = 0, extra_en = 0;
  int resp_dly = 1;
  bit abandon = 1'b0;
  logic [26:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  longint cyc = 0, t_wr_fin = 0, t_rd_en = 0;

  logic [127:0] ddr    [logic [26:0]];
  logic [31:0]  golden [logic [26:0]];
  bit           mv [64];
  bit           md [64];
  logic [16:0]  mt [64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pw(input logic [26:0] a);
    return ({5'b0, a} * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [127:0] mem_line(input logic [26:0] la);
    if (ddr.exists(la)) return ddr[la];
    return {pw(la + 27'd12), pw(la + 27'd8), pw(la + 27'd4), pw(la)};
  endfunction

  // Architectural value of a word: last store, else what DDR holds.
  function automatic logic [31:0] arch_word(input logic [26:0] a);
    logic [26:0]  wa;
    logic [127:0] l;
    wa = {a[26:2], 2'b00};
    if (golden.exists(wa)) return golden[wa];
    l = mem_line({a[26:4], 4'h0});
    return l[wa[3:2]*32 +: 32];
  endfunction

  // DDR responder: fin arrives resp_dly cycles after the en pulse.
  initial begin : responder
    bit is_wr;
    int d;
    rd_fin = 1'b0; wr_fin = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_en === 1'b1 && wr_en === 1'b1) both_err++;
      if (rd_en === 1'b1 || wr_en === 1'b1) begin
        is_wr = (wr_en === 1'b1);
        d = resp_dly;
        if (is_wr) begin
          wr_cnt++; last_wr_addr = wr_addr; last_wr_data = wr_data;
        end else begin
          rd_cnt++; last_rd_addr = rd_addr; t_rd_en = cyc;
        end
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          if (rd_en === 1'b1 || wr_en === 1'b1) extra_en++;
          if (!abandon && (is_wr ? (wr_addr !== last_wr_addr || wr_data !== last_wr_data)
                                 : (rd_addr !== last_rd_addr))) stab_err++;
        end
        if (is_wr) begin
          ddr[last_wr_addr] = last_wr_data; wr_fin = 1'b1; t_wr_fin = cyc;
        end else begin
          rd_data = mem_line(last_rd_addr); rd_fin = 1'b1;
        end
        @(posedge clk); #1;
        rd_fin = 1'b0; wr_fin = 1'b0;
      end
    end
  end

  task automatic access(input bit we, input logic [26:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output bit to);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    lat = 0; to = 1'b1; rd = 'x;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); lat++;
      if (cpu_done === 1'b1) begin
        to = 1'b0; rd = cpu_rdata; break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rstn = 1'b0; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    golden.delete();
    for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({cpu_done, cpu_busy, rd_en, wr_en} !== 4'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {cpu_done, cpu_busy, rd_en, wr_en}); end
    total++; if (cpu_rdata !== 32'h0) begin bad++;
      $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    total++; if (rd_addr !== 27'h0 || wr_addr !== 27'h0 || wr_data !== 128'h0) begin bad++;
      $display("FAIL reset_ddr got rd=%h wr=%h data=%h exp=0", rd_addr, wr_addr, wr_data); end
    rstn = 1'b1;
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int lat; bit to; int r0, w0;
    ddr[27'h40] = 128'h44443333_22221111_00000000_AAAAAAAA;
    resp_dly = 3; r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 27'h40, 32'h0, rd, lat, to);
    total++; if (to || rd !== 32'hAAAAAAAA) begin bad++;
      $display("FAIL cold_rdata got=%h to=%0d exp=aaaaaaaa", rd, to); end
    total++; if (rd_cnt - r0 != 1 || last_rd_addr !== 27'h40) begin bad++;
      $display("FAIL cold_rd_req got n=%0d addr=%h exp n=1 addr=40", rd_cnt - r0, last_rd_addr); end
    total++; if (wr_cnt != w0) begin bad++;
      $display("FAIL cold_no_wr got=%0d exp=0", wr_cnt - w0); end
    r0 = rd_cnt;
    access(1'b0, 27'h44, 32'h0, rd, lat, to);
    total++; if (to || rd !== 32'h0) begin bad++;
      $display("FAIL hit_rdata got=%h exp=00000000", rd); end
    total++; if (lat != 2) begin bad++;
      $display("FAIL hit_latency got=%0d exp=2", lat); end
    total++; if (rd_cnt != r0 || wr_cnt != w0) begin bad++;
      $display("FAIL hit_no_ddr got rd=%0d wr=%0d exp=0", rd_cnt - r0, wr_cnt - w0); end
  endtask

  task automatic test_write_back();
    logic [31:0] rd; int lat; bit to; int r0, w0;
    apply_reset(); resp_dly = 2;
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b1, 27'h48, 32'hDEADBEEF, rd, lat, to);
    total++; if (to || rd_cnt - r0 != 1 || wr_cnt != w0) begin bad++;
      $display("FAIL store_miss got to=%0d rd=%0d wr=%0d exp 0/1/0", to, rd_cnt - r0, wr_cnt - w0); end
    r0 = rd_cnt;
    access(1'b0, 27'h48, 32'h0, rd, lat, to);
    total++; if (rd !== 32'hDEADBEEF) begin bad++;
      $display("FAIL store_then_load got=%h exp=deadbeef", rd); end
    total++; if (lat != 2 || rd_cnt != r0) begin bad++;
      $display("FAIL store_line_hit got lat=%0d rd=%0d exp 2/0", lat, rd_cnt - r0); end
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 27'h448, 32'h0, rd, lat, to);
    total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 27'h40) begin bad++;
      $display("FAIL dirty_wb_addr got n=%0d addr=%h exp n=1 addr=40", wr_cnt - w0, last_wr_addr); end
    total++; if (last_wr_data[95:64] !== 32'hDEADBEEF || last_wr_data[31:0] !== 32'hAAAAAAAA) begin bad++;
      $display("FAIL dirty_wb_data got=%h exp w2=deadbeef w0=aaaaaaaa", last_wr_data); end
    total++; if (rd_cnt - r0 != 1 || last_rd_addr !== 27'h440 || t_rd_en <= t_wr_fin) begin bad++;
      $display("FAIL refill_after_wb got n=%0d addr=%h t_rd=%0d t_fin=%0d exp n=1 addr=440 t_rd>t_fin",
               rd_cnt - r0, last_rd_addr, t_rd_en, t_wr_fin); end
    total++; if (to || rd !== arch_word(27'h448)) begin bad++;
      $display("FAIL evict_load_data got=%h exp=%h", rd, arch_word(27'h448)); end
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b1, 27'h44C, 32'h12345678, rd, lat, to);
    total++; if (to || lat != 2 || rd_cnt != r0 || wr_cnt != w0) begin bad++;
      $display("FAIL clean_store_hit got lat=%0d rd=%0d wr=%0d exp 2/0/0", lat, rd_cnt - r0, wr_cnt - w0); end
    access(1'b0, 27'h40, 32'h0, rd, lat, to);
    total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 27'h440 || last_wr_data[127:96] !== 32'h12345678) begin bad++;
      $display("FAIL store_hit_wb got n=%0d addr=%h w3=%h exp n=1 addr=440 w3=12345678",
               wr_cnt - w0, last_wr_addr, last_wr_data[127:96]); end
    total++; if (rd !== 32'hAAAAAAAA) begin bad++;
      $display("FAIL reload_rdata got=%h exp=aaaaaaaa", rd); end
    r0 = rd_cnt; w0 = wr_cnt;
    access(1'b0, 27'h840, 32'h0, rd, lat, to);
    total++; if (to || wr_cnt != w0 || rd_cnt - r0 != 1) begin bad++;
      $display("FAIL clean_evict got wr=%0d rd=%0d exp 0/1", wr_cnt - w0, rd_cnt - r0); end
  endtask

  task automatic test_delays();
    logic [31:0] rd; int lat; bit to; int r0, w0, st0, x0, dly;
    for (int k = 0; k < 2; k++) begin
      dly = (k == 0) ? 1 : 20;
      apply_reset(); resp_dly = dly; st0 = stab_err; x0 = extra_en;
      access(1'b1, 27'h2050, 32'hC0DE0000 + dly, rd, lat, to);
      r0 = rd_cnt; w0 = wr_cnt;
      access(1'b0, 27'h3050, 32'h0, rd, lat, to);
      total++; if (to || rd !== arch_word(27'h3050)) begin bad++;
        $display("FAIL dly%0d_rdata got=%h exp=%h", dly, rd, arch_word(27'h3050)); end
      total++; if (wr_cnt - w0 != 1 || last_wr_addr !== 27'h2050 || last_wr_data[31:0] !== 32'hC0DE0000 + dly) begin bad++;
        $display("FAIL dly%0d_wb got n=%0d addr=%h w0=%h exp n=1 addr=2050 w0=%h",
                 dly, wr_cnt - w0, last_wr_addr, last_wr_data[31:0], 32'hC0DE0000 + dly); end
      total++; if (rd_cnt - r0 != 1 || last_rd_addr !== 27'h3050) begin bad++;
        $display("FAIL dly%0d_rf got n=%0d addr=%h exp n=1 addr=3050", dly, rd_cnt - r0, last_rd_addr); end
      total++; if (stab_err != st0 || extra_en != x0) begin bad++;
        $display("FAIL dly%0d_stable got stab=%0d extra=%0d exp 0/0", dly, stab_err - st0, extra_en - x0); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; bit to; int r0, dn; bit seen;
    resp_dly = 20; r0 = rd_cnt; abandon = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 27'h5060; cpu_wdata = '0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rd_cnt != r0) seen = 1'b1;
    end
    total++; if (!seen) begin bad++;
      $display("FAIL rstmid_req got no rd_en exp rd_en within 50 cycles"); end
    repeat (3) @(negedge clk);
    rstn = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    total++; if ({cpu_done, cpu_busy, rd_en, wr_en} !== 4'b0 || cpu_rdata !== 32'h0 ||
                 rd_addr !== 27'h0 || wr_addr !== 27'h0 || wr_data !== 128'h0) begin bad++;
      $display("FAIL rstmid_outputs got ctrl=%b rdata=%h rd=%h wr=%h exp all 0",
               {cpu_done, cpu_busy, rd_en, wr_en}, cpu_rdata, rd_addr, wr_addr); end
    rstn = 1'b1; dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_done === 1'b1 || cpu_busy === 1'b1) dn++;
    end
    total++; if (dn != 0) begin bad++;
      $display("FAIL rstmid_late_fin got active=%0d exp=0", dn); end
    abandon = 1'b0; resp_dly = 1; r0 = rd_cnt;
    access(1'b0, 27'h5060, 32'h0, rd, lat, to);
    total++; if (to || rd_cnt - r0 != 1) begin bad++;
      $display("FAIL rstmid_remiss got n=%0d to=%0d exp n=1", rd_cnt - r0, to); end
    total++; if (rd !== arch_word(27'h5060)) begin bad++;
      $display("FAIL rstmid_rdata got=%h exp=%h", rd, arch_word(27'h5060)); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 200; n++) begin
      bit we, hit, wb, to;
      logic [26:0] a, va;
      logic [31:0] wd, rd, exp_rd;
      logic [127:0] vline;
      logic [16:0] tg;
      int idx, lat, r0, w0;
      tg  = 17'h20 + 17'($urandom_range(0, 3));
      idx = 8 + $urandom_range(0, 3);
      a   = {tg, 6'(idx), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      resp_dly = $urandom_range(1, 4);
      hit = mv[idx] && (mt[idx] == tg);
      wb  = !hit && mv[idx] && md[idx];
      va  = {mt[idx], 6'(idx), 4'h0};
      vline  = {arch_word(va + 27'd12), arch_word(va + 27'd8), arch_word(va + 27'd4), arch_word(va)};
      exp_rd = arch_word(a);
      r0 = rd_cnt; w0 = wr_cnt;
      access(we, a, wd, rd, lat, to);
      total++; if (to) begin bad++;
        $display("FAIL rnd%0d_timeout got no done exp done", n); end
      if (!we) begin
        total++; if (rd !== exp_rd) begin bad++;
          $display("FAIL rnd%0d_rdata addr=%h got=%h exp=%h", n, a, rd, exp_rd); end
      end
      total++; if (rd_cnt - r0 != (hit ? 0 : 1) || wr_cnt - w0 != (wb ? 1 : 0)) begin bad++;
        $display("FAIL rnd%0d_traffic got rd=%0d wr=%0d exp rd=%0d wr=%0d",
                 n, rd_cnt - r0, wr_cnt - w0, !hit, wb); end
      if (wb) begin
        total++; if (last_wr_addr !== va || last_wr_data !== vline) begin bad++;
          $display("FAIL rnd%0d_wb got addr=%h data=%h exp addr=%h data=%h", n, last_wr_addr, last_wr_data, va, vline); end
      end
      if (!hit) begin
        total++; if (last_rd_addr !== {a[26:4], 4'h0}) begin bad++;
          $display("FAIL rnd%0d_rf_addr got=%h exp=%h", n, last_rd_addr, {a[26:4], 4'h0}); end
      end else begin
        total++; if (lat != 2) begin bad++;
          $display("FAIL rnd%0d_hit_lat got=%0d exp=2", n, lat); end
      end
      if (we) golden[{a[26:2], 2'b00}] = wd;
      if (!hit) begin
        mv[idx] = 1'b1; mt[idx] = tg; md[idx] = we;
      end else if (we) begin
        md[idx] = 1'b1;
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (both_err != 0) begin bad++;
      $display("FAIL both_en got=%0d exp=0", both_err); end
    total++; if (extra_en != 0 || stab_err != 0) begin bad++;
      $display("FAIL req_protocol got extra=%0d unstable=%0d exp 0/0", extra_en, stab_err); end
  endtask

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; rstn = 1'b0;
    test_reset();
    test_cold_load();
    test_write_back();
    test_delays();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ddr_initiator.md
Name: dcache_ddr_initiator

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between a 32-bit CPU load/store port and the 128-bit line DDR request/response interface.
- It is the initiator side of that interface. It issues line reads (refill) and line writes (write-back). It waits for the DDR side's rd_fin/wr_fin completion pulses.
- Sits between the core's memory stage and the DDR model or controller.

Parameters:
- ADDR_W, 27, byte address width on both the CPU and DDR sides.
- INDEX_W, 6, line index bits; the cache holds 2^INDEX_W lines.
- LINE_W, 128, line width; fixed at 4 words of 32 bits.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  27  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data; valid while cpu_done=1
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  high in every state except IDLE
- cache2DDR_rd_addr  out  27  refill line address, low 4 bits 0
- cache2DDR_rd_en  out  1  one-cycle refill request pulse
- DDR2cache_rd_fin  in  1  refill complete; rd_data valid in the same cycle
- DDR2cache_rd_data  in  128  refill line
- cache2DDR_wr_addr  out  27  victim line address, low 4 bits 0
- cache2DDR_wr_data  out  128  victim line
- cache2DDR_wr_en  out  1  one-cycle write-back request pulse
- DDR2cache_wr_fin  in  1  write-back complete

Behaviour:
- Address split:
  - word offset = addr[3:2]
  - index = addr[4+INDEX_W-1:4]
  - tag = addr[26:4+INDEX_W]
- Line word k occupies bits [32k+31:32k].
- Storage:
  - valid[], dirty[] and tag[] register arrays.
  - Data array of 2^INDEX_W × 128 bits.
- Reset (rstn=0 at a clk edge):
  - state ← IDLE; all valid and dirty bits ← 0; data and tags are not cleared.
  - cpu_done, cpu_busy, rd_en, wr_en ← 0; cpu_rdata, rd_addr, wr_addr, wr_data ← 0.
  - Reset mid-transaction abandons the transaction.
  - A fin pulse arriving after reset is ignored, because fin is sampled only in the WAIT states.
- All outputs are registered.
- States:
  - IDLE: if cpu_req, latch addr, we and wdata, then go to LOOKUP.
  - LOOKUP (hit = valid & tag match):
    - Hit load: cpu_rdata ← the selected word, cpu_done ← 1, go to IDLE.
    - Hit store: write the word, set dirty, cpu_done ← 1, go to IDLE.
    - Miss with victim valid and dirty: go to WB_REQ.
    - Any other miss: go to RF_REQ.
  - WB_REQ:
    - wr_en ← 1 for exactly one cycle.
    - wr_addr ← {victim tag, index, 4'b0}; wr_data ← victim line.
    - Go to WB_WAIT.
  - WB_WAIT:
    - wr_addr and wr_data are held stable.
    - On wr_fin: clear dirty, go to RF_REQ.
  - RF_REQ: rd_en ← 1 for one cycle, rd_addr ← {tag, index, 4'b0}, go to RF_WAIT.
  - RF_WAIT: on rd_fin:
    - Install rd_data with the latched store word merged in when we=1.
    - Set valid, set dirty=we, write tag.
    - cpu_rdata ← the selected word of the merged line; cpu_done ← 1; go to IDLE.
- Timing:
  - Hit latency: cpu_req sampled at edge n, cpu_done high during cycle n+2.
  - Miss: done is high in the cycle after rd_fin is sampled.
- Handshake rules:
  - rd_en and wr_en are never high in the same cycle.
  - At most one DDR request is outstanding.
  - Request addresses and data stay stable from the en pulse until the matching fin.
  - A fin is accepted only in its own WAIT state.
  - wr_fin seen in RF_WAIT (or vice versa) is ignored.
  - The responder may return fin on the cycle right after en; a 1-cycle response must work.
- cpu_req while busy is ignored; the CPU holds its request until cpu_done.
- A clean miss never writes back.
- An invalid victim never writes back, even if stale data is present.

Decomposition:
- Shared package dcache_pkg:
  - ADDR_W, LINE_W, WORD_W and OFFSET_W=4 constants.
  - State enumeration (IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT).
  - Tag and index width functions.
- One sub-module, dcache_store: the tag, valid, dirty and data arrays with a single read/write port and the word-merge logic. The FSM stays in the top.

Test Plan:
- Cold load at 0x0000040, responder returning line 0x44443333_22221111_00000000_AAAAAAAA:
  - Expect rd_en with rd_addr=0x0000040 and no wr_en.
  - Expect cpu_done with cpu_rdata=0xAAAAAAAA.
  - A repeated load of 0x0000044 must hit with cpu_rdata=0x00000000, done at n+2, no DDR traffic.
- Store 0xDEADBEEF to 0x0000048 (miss), then load 0x0000048 → refill once, then hit returning 0xDEADBEEF; the line is dirty.
- Dirty eviction: after the previous case, load 0x0000448 (same index 4, different tag):
  - Expect wr_en with wr_addr=0x0000040 and wr_data word 2 = 0xDEADBEEF.
  - Then rd_en with rd_addr=0x0000440 only after wr_fin.
- Store hit on a clean line, then evict it → exactly one write-back carrying the new word. A clean evict produces no wr_en.
- Responder with fin delayed 1 and 20 cycles → identical results; addr/data stable across the wait; no second en pulse.
- rstn low during RF_WAIT, then a late rd_fin:
  - All outputs are 0 and state is IDLE.
  - The next load to the same address misses again, because valid was cleared.
